// File: rtl/task_1.sv
// rtl/task_1.sv - three-lamp traffic-light Moore controller (RED -> GREEN -> YELLOW)
// Optional RED_YELLOW phase between RED and GREEN when TASK1_RED_YELLOW_EN is defined.
module task_1 #(
   parameter int RED_CYCLES        = 5,
   parameter int GREEN_CYCLES      = 4,
   parameter int YELLOW_CYCLES     = 2,
   parameter int RED_YELLOW_CYCLES = 1,
   parameter int CNT_W             = 8
) (
   input  logic i_w_clk,
   input  logic i_w_reset,
   output logic o_w_red,
   output logic o_w_yellow,
   output logic o_w_green
);

   typedef enum logic [1:0] {
      RED        = 2'd0,
      GREEN      = 2'd1,
      YELLOW     = 2'd2,
      RED_YELLOW = 2'd3
   } state_t;

   localparam longint MAX_DUR = (longint'(1) << CNT_W) - 1;

   // A duration of 0 behaves as 1 so no phase is ever skipped.
   function automatic logic [CNT_W-1:0] last_of(input int cycles);
      return (cycles <= 1) ? '0 : CNT_W'(cycles - 1);
   endfunction

   localparam logic [CNT_W-1:0] RED_LAST    = last_of(RED_CYCLES);
   localparam logic [CNT_W-1:0] GREEN_LAST  = last_of(GREEN_CYCLES);
   localparam logic [CNT_W-1:0] YELLOW_LAST = last_of(YELLOW_CYCLES);

   if (longint'(RED_CYCLES) > MAX_DUR) begin : g_red_range
      $error("RED_CYCLES exceeds 2**CNT_W-1");
   end
   if (longint'(GREEN_CYCLES) > MAX_DUR) begin : g_green_range
      $error("GREEN_CYCLES exceeds 2**CNT_W-1");
   end
   if (longint'(YELLOW_CYCLES) > MAX_DUR) begin : g_yellow_range
      $error("YELLOW_CYCLES exceeds 2**CNT_W-1");
   end

`ifdef TASK1_RED_YELLOW_EN
   localparam logic [CNT_W-1:0] RY_LAST = last_of(RED_YELLOW_CYCLES);
   if (longint'(RED_YELLOW_CYCLES) > MAX_DUR) begin : g_ry_range
      $error("RED_YELLOW_CYCLES exceeds 2**CNT_W-1");
   end
`endif

   logic [1:0]       state;
   logic [1:0]       state_d;
   logic [1:0]       phase_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] phase_last;
   logic             legal;

   always_comb begin
      legal      = 1'b1;
      phase_last = RED_LAST;
      phase_next = GREEN;
      case (state)
         RED: begin
            phase_last = RED_LAST;
`ifdef TASK1_RED_YELLOW_EN
            phase_next = RED_YELLOW;
`else
            phase_next = GREEN;
`endif
         end
         GREEN: begin
            phase_last = GREEN_LAST;
            phase_next = YELLOW;
         end
         YELLOW: begin
            phase_last = YELLOW_LAST;
            phase_next = RED;
         end
`ifdef TASK1_RED_YELLOW_EN
         RED_YELLOW: begin
            phase_last = RY_LAST;
            phase_next = GREEN;
         end
`endif
         default: legal = 1'b0;
      endcase

      // >= rather than == so a corrupted counter still ends the phase.
      if (!legal) begin
         state_d = RED;
         cnt_d   = '0;
      end else if (cnt >= phase_last) begin
         state_d = phase_next;
         cnt_d   = '0;
      end else begin
         state_d = state;
         cnt_d   = cnt + 1'b1;
      end
   end

   always_ff @(posedge i_w_clk or negedge i_w_reset) begin
      if (!i_w_reset) begin
         state      <= RED;
         cnt        <= '0;
         o_w_red    <= 1'b1;
         o_w_yellow <= 1'b0;
         o_w_green  <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         o_w_red    <= (state_d == RED) || (state_d == RED_YELLOW);
         o_w_yellow <= (state_d == YELLOW) || (state_d == RED_YELLOW);
         o_w_green  <= (state_d == GREEN);
      end
   end

endmodule

// File: tb/tb_task_1.sv
// tb/tb_task_1.sv - directed self-checking bench for task_1 (optionally with TASK1_RED_YELLOW_EN)
module tb_task_1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic red, yel, grn;
   logic red2, yel2, grn2;
   int   tests = 0;
   int   fails = 0;

`ifdef TASK1_RED_YELLOW_EN
   localparam int RY_LEN  = 2;
   localparam int RY2_LEN = 1;
`else
   localparam int RY_LEN  = 0;
   localparam int RY2_LEN = 0;
`endif

   task_1 #(
      .RED_CYCLES(5), .GREEN_CYCLES(4), .YELLOW_CYCLES(2),
      .RED_YELLOW_CYCLES(2), .CNT_W(8)
   ) dut (
      .i_w_clk(clk), .i_w_reset(rst_n),
      .o_w_red(red), .o_w_yellow(yel), .o_w_green(grn)
   );

   task_1 #(
      .RED_CYCLES(1), .GREEN_CYCLES(1), .YELLOW_CYCLES(1),
      .RED_YELLOW_CYCLES(1), .CNT_W(8)
   ) dut2 (
      .i_w_clk(clk), .i_w_reset(rst_n),
      .o_w_red(red2), .o_w_yellow(yel2), .o_w_green(grn2)
   );

   always #5 clk = ~clk;

   // Lamps {red,yellow,green} expected j edges after the RED phase (re)starts.
   function automatic logic [2:0] exp_lamps(input int j, input int r, input int ry,
                                            input int g, input int y);
      int m;
      m = j % (r + ry + g + y);
      if (m < r)           return 3'b100;
      if (m < r + ry)      return 3'b110;
      if (m < r + ry + g)  return 3'b001;
      return 3'b010;
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int e = 0; e < 3; e++) begin
         @(negedge clk);
         check($sformatf("reset_hold_%0d", e), {5'd0, red, yel, grn}, 8'b100);
         check($sformatf("reset_hold2_%0d", e), {5'd0, red2, yel2, grn2}, 8'b100);
      end

      rst_n = 1'b1;
      for (int j = 0; j < 33; j++) begin
         check($sformatf("run_%0d", j), {5'd0, red, yel, grn},
               {5'd0, exp_lamps(j, 5, RY_LEN, 4, 2)});
         check($sformatf("run_min_%0d", j), {5'd0, red2, yel2, grn2},
               {5'd0, exp_lamps(j, 1, RY2_LEN, 1, 1)});
         @(negedge clk);
      end

      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int j = 1; j <= 5 + RY_LEN + 1; j++) @(negedge clk);
      check("mid_green", {5'd0, red, yel, grn}, 8'b001);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_lamps", {5'd0, red, yel, grn}, 8'b100);
      check("async_reset_cnt", dut.cnt, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 13; j++) begin
         check($sformatf("after_reset_%0d", j), {5'd0, red, yel, grn},
               {5'd0, exp_lamps(j, 5, RY_LEN, 4, 2)});
         @(negedge clk);
      end

`ifndef TASK1_RED_YELLOW_EN
      for (int j = 0; j < 6; j++) @(negedge clk);
      force dut.state = 2'd3;
      #1;
      release dut.state;
      @(negedge clk);
      check("illegal_lamps", {5'd0, red, yel, grn}, 8'b100);
      check("illegal_cnt", dut.cnt, 8'd0);
      check("illegal_state", {6'd0, dut.state}, 8'd0);
      for (int j = 1; j < 12; j++) begin
         @(negedge clk);
         check($sformatf("recover_%0d", j), {5'd0, red, yel, grn},
               {5'd0, exp_lamps(j, 5, 0, 4, 2)});
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
